// File: rtl/fu_alu_pkg.sv
// fu_pkg: opcodes, flag bit positions, CDB entry type and flag packing for fu_alu
package fu_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_ADC  = 4'd1,
      OP_SUB  = 4'd2,
      OP_AND  = 4'd3,
      OP_OR   = 4'd4,
      OP_XOR  = 4'd5,
      OP_SHL  = 4'd6,
      OP_SHR  = 4'd7,
      OP_PASS = 4'd8,
      OP_MUL  = 4'd9
   } opcode_e;

   localparam int FLAG_C   = 0;
   localparam int FLAG_Z   = 1;
   localparam int FLAG_N   = 2;
   localparam int FLAG_V   = 3;
   localparam int FLAG_ILL = 7;

   localparam logic [3:0] CDB_IDLE_TAG = 4'h0;

   typedef struct packed {
      logic [3:0] robid;
      logic [7:0] val;
      logic [7:0] flags;
      logic [7:0] wbs;
   } cdb_entry_t;

   function automatic logic [7:0] make_flags(input logic [7:0] r, input logic c, input logic v, input logic ill);
      logic [7:0] f;
      f = '0;
      f[FLAG_C]   = c;
      f[FLAG_Z]   = r == 8'h00;
      f[FLAG_N]   = r[7];
      f[FLAG_V]   = v;
      f[FLAG_ILL] = ill;
      return f;
   endfunction

endpackage

// File: rtl/fu_alu_if.sv
// fu_alu_if: FU issue bus plus CDB request/grant/result bus
interface fu_alu_if;
   logic            futransmit;
   logic [7:0]      operand;
   logic [7:0]      wbs;
   logic [1:0][7:0] depvals;
   logic [7:0]      flag;
   logic [3:0]      robid;
   logic            fu_busy;
   logic            cdb_req;
   logic            cdb_grant;
   logic [3:0]      cdb_robid;
   logic [7:0]      cdb_val;
   logic [7:0]      cdb_flags;
   logic [7:0]      cdb_wbs;

   modport master (
      output futransmit, operand, wbs, depvals, flag, robid, cdb_grant,
      input  fu_busy, cdb_req, cdb_robid, cdb_val, cdb_flags, cdb_wbs
   );

   modport slave (
      input  futransmit, operand, wbs, depvals, flag, robid, cdb_grant,
      output fu_busy, cdb_req, cdb_robid, cdb_val, cdb_flags, cdb_wbs
   );
endinterface

// File: rtl/fu_alu_result_fifo.sv
// fu_result_fifo: completion-ordered result queue with wrap-bit pointers
module fu_result_fifo
   import fu_pkg::*;
#(
   parameter int  DEPTH = 2,
   parameter type T     = cdb_entry_t
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  T                       din,
   input  logic                   pop,
   output T                       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   T           mem [DEPTH];
   logic [AW:0] wp, rp;
   logic        do_push, do_pop;

   assign empty   = wp == rp;
   assign full    = wp == {~rp[AW], rp[AW-1:0]};
   assign count   = wp - rp;
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rp[AW-1:0]];

   // pointer advance; a pop on an empty queue is dropped so results never bypass storage
   always_ff @(posedge clk) begin
      if (rst) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop) rp <= rp + 1'b1;
      end
   end

   // entry storage written at the tail; contents are don't-care until pushed
   always_ff @(posedge clk) begin
      if (do_push) mem[wp[AW-1:0]] <= din;
   end
endmodule

// File: rtl/fu_alu.sv
// fu_alu: 8-bit integer FU feeding the CDB through a result queue; define FU_MUL_EN to build the multiplier
module fu_alu
   import fu_pkg::*;
#(
   parameter int RQ_DEPTH = 2,
   parameter int MUL_LAT  = 3
) (
   input logic     clk,
   input logic     rst,
   fu_alu_if.slave bus
);
   localparam int CW = $clog2(RQ_DEPTH) + 1;

   logic [3:0]    op;
   logic [7:0]    a, b, res;
   logic [8:0]    add_w, sub_w, shl_w, shr_w;
   logic          c, v, accept, is_mul, alu_ill, push, pop, full, empty, mul_active;
   logic [CW-1:0] count;
   cdb_entry_t    alu_e, push_e, head;

   assign op     = bus.operand[3:0];
   assign a      = bus.depvals[0];
   assign b      = bus.depvals[1];
   assign is_mul = op == OP_MUL;
   assign accept = bus.futransmit && !bus.fu_busy;
   assign pop    = bus.cdb_req && bus.cdb_grant;

   // single-cycle datapath; illegal codes fall through to a zero result
   always_comb begin
      add_w = {1'b0, a} + {1'b0, b} + {8'h00, op == OP_ADC && bus.flag[0]};
      sub_w = {1'b0, a} - {1'b0, b};
      shl_w = {1'b0, a} << b[2:0];
      shr_w = {a, 1'b0} >> b[2:0];
      res   = (op == OP_ADD || op == OP_ADC) ? add_w[7:0] :
              op == OP_SUB  ? sub_w[7:0] :
              op == OP_AND  ? a & b :
              op == OP_OR   ? a | b :
              op == OP_XOR  ? a ^ b :
              op == OP_SHL  ? shl_w[7:0] :
              op == OP_SHR  ? shr_w[8:1] :
              op == OP_PASS ? b : 8'h00;
      c     = (op == OP_ADD || op == OP_ADC) ? add_w[8] :
              op == OP_SUB ? sub_w[8] :
              op == OP_SHL ? shl_w[8] :
              op == OP_SHR ? shr_w[0] : 1'b0;
      v     = (op == OP_ADD || op == OP_ADC) ? (a[7] == b[7]) && (res[7] != a[7]) :
              op == OP_SUB ? (a[7] != b[7]) && (res[7] != a[7]) : 1'b0;
      alu_e = '{robid: bus.robid, val: res, flags: make_flags(res, c, v, alu_ill), wbs: bus.wbs};
   end

`ifdef FU_MUL_EN
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_MUL  = 1'b1;

   logic [0:0] state;
   logic [7:0] cnt, ma, mb, prod, m_wbs;
   logic [3:0] m_robid;
   cdb_entry_t mul_e;

   // multiplier: latch on issue, count MUL_LAT down, write the queue at zero and return to idle
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else if (state == S_IDLE) begin
         if (accept && is_mul) begin
            state   <= S_MUL;
            cnt     <= MUL_LAT[7:0];
            ma      <= a;
            mb      <= b;
            m_robid <= bus.robid;
            m_wbs   <= bus.wbs;
         end
      end else if (cnt == 8'd0) begin
         state <= S_IDLE;
      end else begin
         cnt <= cnt - 8'd1;
      end
   end

   assign mul_active = state == S_MUL;
   assign prod       = ma * mb;
   assign mul_e      = '{robid: m_robid, val: prod, flags: make_flags(prod, 1'b0, 1'b0, 1'b0), wbs: m_wbs};
   assign alu_ill    = op > OP_MUL;
   assign push       = (accept && !is_mul) || (mul_active && cnt == 8'd0);
   assign push_e     = mul_active ? mul_e : alu_e;
`else
   assign mul_active = 1'b0;
   assign alu_ill    = is_mul || op > OP_MUL;
   assign push       = accept;
   assign push_e     = alu_e;
`endif

   // every accepted op owns a queue slot, so a push never meets a full queue
   assign bus.fu_busy = 32'(count) + 32'(mul_active) >= 32'(RQ_DEPTH) || mul_active;

   fu_result_fifo #(.DEPTH(RQ_DEPTH), .T(cdb_entry_t)) rq (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (push_e),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign bus.cdb_req   = !empty;
   assign bus.cdb_robid = empty ? CDB_IDLE_TAG : head.robid;
   assign bus.cdb_val   = empty ? 8'h00 : head.val;
   assign bus.cdb_flags = empty ? 8'h00 : head.flags;
   assign bus.cdb_wbs   = empty ? 8'h00 : head.wbs;
endmodule

// File: tb/tb_fu_alu.sv
// tb_fu_alu: directed and randomized checks of fu_alu against an arithmetic reference model
module tb_fu_alu;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   passed = 0;

   always #5 clk = ~clk;

   fu_alu_if bus();

   fu_alu #(.RQ_DEPTH(2), .MUL_LAT(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // returns {flags, value} from plain integer arithmetic
   function automatic logic [15:0] ref_alu(int op, int a, int b, int cin);
      int r, c, v, sa, sb, s, t;
      bit ill;
      sa = a > 127 ? a - 256 : a;
      sb = b > 127 ? b - 256 : b;
      s = b % 8;
      r = 0; c = 0; v = 0; ill = 0;
      case (op)
         0, 1: begin
            t = op == 1 ? cin : 0;
            r = a + b + t;
            c = r > 255 ? 1 : 0;
            v = (sa + sb + t > 127 || sa + sb + t < -128) ? 1 : 0;
         end
         2: begin
            r = a - b;
            c = r < 0 ? 1 : 0;
            v = (sa - sb > 127 || sa - sb < -128) ? 1 : 0;
         end
         3: r = a & b;
         4: r = a | b;
         5: r = a ^ b;
         6: begin
            r = a << s;
            c = s != 0 ? (a >> (8 - s)) & 1 : 0;
         end
         7: begin
            r = a >> s;
            c = s != 0 ? (a >> (s - 1)) & 1 : 0;
         end
         8: r = b;
`ifdef FU_MUL_EN
         9: r = a * b;
`endif
         default: ill = 1;
      endcase
      r = r & 255;
      return ill ? 16'h8200 : {8'(c | (r == 0 ? 2 : 0) | (r > 127 ? 4 : 0) | (v != 0 ? 8 : 0)), 8'(r)};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic [3:0] robid, input logic [7:0] wbs);
      bus.futransmit = 1'b1;
      bus.operand    = {4'($urandom), op};
      bus.depvals[0] = a;
      bus.depvals[1] = b;
      bus.flag       = {7'($urandom), cin};
      bus.robid      = robid;
      bus.wbs        = wbs;
   endtask

   task automatic idle;
      bus.futransmit = 1'b0;
      bus.operand    = '0;
      bus.depvals    = '0;
      bus.flag       = '0;
      bus.robid      = '0;
      bus.wbs        = '0;
   endtask

   task automatic test_reset;
      logic [29:0] got;
      rst = 1'b1;
      idle();
      bus.cdb_grant = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      got = {bus.fu_busy, bus.cdb_req, bus.cdb_robid, bus.cdb_val, bus.cdb_flags, bus.cdb_wbs};
      checks++;
      if (got !== 30'h0) $display("FAIL reset_outputs: got %h expected %h", got, 30'h0);
      else passed++;
      tick();
      got = {bus.fu_busy, bus.cdb_req, bus.cdb_robid, bus.cdb_val, bus.cdb_flags, bus.cdb_wbs};
      checks++;
      if (got !== 30'h0) $display("FAIL post_reset_idle: got %h expected %h", got, 30'h0);
      else passed++;
   endtask

   task automatic test_directed;
      logic [3:0]  ops [5] = '{4'h0, 4'h2, 4'h2, 4'hC, 4'h1};
      logic [7:0]  as  [5] = '{8'h7F, 8'h05, 8'h00, 8'h12, 8'hFF};
      logic [7:0]  bs  [5] = '{8'h01, 8'h05, 8'h01, 8'h34, 8'h00};
      logic [28:0] exp [5] = '{{1'b1, 4'd3, 8'h80, 8'h0C, 8'h5A},
                               {1'b1, 4'd4, 8'h00, 8'h02, 8'h11},
                               {1'b1, 4'd5, 8'hFF, 8'h05, 8'h22},
                               {1'b1, 4'd6, 8'h00, 8'h82, 8'h44},
                               {1'b1, 4'd7, 8'h00, 8'h03, 8'h55}};
      logic [7:0]  wb  [5] = '{8'h5A, 8'h11, 8'h22, 8'h44, 8'h55};
      logic [28:0] got;
      bus.cdb_grant = 1'b1;
      for (int i = 0; i < 5; i++) begin
         issue(ops[i], as[i], bs[i], 1'b1, 4'(i + 3), wb[i]);
         tick();
         got = {bus.cdb_req, bus.cdb_robid, bus.cdb_val, bus.cdb_flags, bus.cdb_wbs};
         checks++;
         if (got !== exp[i]) $display("FAIL directed_%0d: got %h expected %h", i, got, exp[i]);
         else passed++;
      end
      idle();
      tick();
      got = {bus.cdb_req, bus.cdb_robid, bus.cdb_val, bus.cdb_flags, bus.cdb_wbs};
      checks++;
      if (got !== 29'h0) $display("FAIL directed_drain: got %h expected %h", got, 29'h0);
      else passed++;
      bus.cdb_grant = 1'b0;
   endtask

   task automatic test_backpressure;
      logic [12:0] got;
      bus.cdb_grant = 1'b0;
      issue(4'h0, 8'h01, 8'h01, 1'b0, 4'd1, 8'hA1);
      tick();
      checks++;
      if (bus.fu_busy !== 1'b0) $display("FAIL bp_first_busy: got %b expected 0", bus.fu_busy);
      else passed++;
      issue(4'h0, 8'h02, 8'h02, 1'b0, 4'd2, 8'hA2);
      tick();
      issue(4'h0, 8'h03, 8'h03, 1'b0, 4'd3, 8'hA3);
      checks++;
      if (bus.fu_busy !== 1'b1) $display("FAIL bp_full_busy: got %b expected 1", bus.fu_busy);
      else passed++;
      tick();
      got = {bus.fu_busy, bus.cdb_robid, bus.cdb_val};
      checks++;
      if (got !== {1'b1, 4'd1, 8'h02}) $display("FAIL bp_third_held: got %h expected %h", got, {1'b1, 4'd1, 8'h02});
      else passed++;
      bus.cdb_grant = 1'b1;
      tick();
      bus.cdb_grant = 1'b0;
      got = {bus.fu_busy, bus.cdb_robid, bus.cdb_val};
      checks++;
      if (got !== {1'b0, 4'd2, 8'h04}) $display("FAIL bp_after_grant: got %h expected %h", got, {1'b0, 4'd2, 8'h04});
      else passed++;
      tick();
      idle();
      got = {bus.fu_busy, bus.cdb_robid, bus.cdb_val};
      checks++;
      if (got !== {1'b1, 4'd2, 8'h04}) $display("FAIL bp_third_accepted: got %h expected %h", got, {1'b1, 4'd2, 8'h04});
      else passed++;
      bus.cdb_grant = 1'b1;
      tick();
      checks++;
      if ({bus.cdb_robid, bus.cdb_val, bus.cdb_wbs} !== {4'd3, 8'h06, 8'hA3})
         $display("FAIL bp_third_result: got %h expected %h", {bus.cdb_robid, bus.cdb_val, bus.cdb_wbs}, {4'd3, 8'h06, 8'hA3});
      else passed++;
      tick();
      bus.cdb_grant = 1'b0;
      checks++;
      if (bus.cdb_req !== 1'b0) $display("FAIL bp_drained: got %b expected 0", bus.cdb_req);
      else passed++;
   endtask

   task automatic test_mul;
      logic [29:0] got;
      bus.cdb_grant = 1'b0;
      issue(4'h9, 8'h10, 8'h11, 1'b0, 4'd5, 8'h33);
      tick();
      idle();
`ifdef FU_MUL_EN
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({bus.fu_busy, bus.cdb_req} !== 2'b10) $display("FAIL mul_wait_%0d: got %b expected 10", i, {bus.fu_busy, bus.cdb_req});
         else passed++;
         tick();
      end
      got = {bus.fu_busy, bus.cdb_req, bus.cdb_robid, bus.cdb_val, bus.cdb_flags, bus.cdb_wbs};
      checks++;
      if (got !== {1'b0, 1'b1, 4'd5, 8'h10, 8'h00, 8'h33}) $display("FAIL mul_result: got %h expected %h", got, {1'b0, 1'b1, 4'd5, 8'h10, 8'h00, 8'h33});
      else passed++;
`else
      got = {bus.fu_busy, bus.cdb_req, bus.cdb_robid, bus.cdb_val, bus.cdb_flags, bus.cdb_wbs};
      checks++;
      if (got !== {1'b0, 1'b1, 4'd5, 8'h00, 8'h82, 8'h33}) $display("FAIL mul_illegal: got %h expected %h", got, {1'b0, 1'b1, 4'd5, 8'h00, 8'h82, 8'h33});
      else passed++;
`endif
      bus.cdb_grant = 1'b1;
      tick();
      bus.cdb_grant = 1'b0;
      checks++;
      if (bus.cdb_req !== 1'b0) $display("FAIL mul_drained: got %b expected 0", bus.cdb_req);
      else passed++;
   endtask

   task automatic test_reset_mid;
      logic [29:0] got;
      bus.cdb_grant = 1'b0;
      issue(4'h0, 8'h01, 8'h01, 1'b0, 4'd7, 8'h77);
      tick();
      issue(4'h9, 8'h03, 8'h04, 1'b0, 4'd8, 8'h88);
      tick();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      got = {bus.fu_busy, bus.cdb_req, bus.cdb_robid, bus.cdb_val, bus.cdb_flags, bus.cdb_wbs};
      checks++;
      if (got !== 30'h0) $display("FAIL mid_reset_outputs: got %h expected %h", got, 30'h0);
      else passed++;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if ({bus.fu_busy, bus.cdb_req} !== 2'b00) $display("FAIL mid_reset_late_%0d: got %b expected 00", i, {bus.fu_busy, bus.cdb_req});
         else passed++;
      end
   endtask

   // random traffic, then a fill followed by saturated issue+grant so the pointers wrap many times
   task automatic test_traffic;
      logic [27:0] q [$];
      logic [27:0] exp_head, got;
      logic [15:0] r;
      logic [7:0]  a, b, wbs;
      logic [3:0]  op, robid;
      logic        g, tx, cin, exp_busy;
      for (int i = 0; i < 330; i++) begin
         exp_busy = q.size() >= 2;
         exp_head = q.size() != 0 ? q[0] : 28'h0;
         got = {bus.cdb_robid, bus.cdb_val, bus.cdb_flags, bus.cdb_wbs};
         checks++;
         if ({bus.fu_busy, bus.cdb_req} !== {exp_busy, q.size() != 0})
            $display("FAIL traffic_ctrl_%0d: got %b expected %b", i, {bus.fu_busy, bus.cdb_req}, {exp_busy, q.size() != 0});
         else passed++;
         checks++;
         if (got !== exp_head) $display("FAIL traffic_head_%0d: got %h expected %h", i, got, exp_head);
         else passed++;
         g  = i < 300 ? $urandom_range(0, 3) != 0 : i >= 303;
         tx = i < 300 ? $urandom_range(0, 9) < 7 : 1'b1;
         op = 4'($urandom_range(0, 15));
`ifdef FU_MUL_EN
         if (op == 4'h9) op = 4'h8;
`endif
         a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
         robid = 4'($urandom_range(1, 15)); wbs = 8'($urandom);
         bus.cdb_grant = g;
         if (tx) issue(op, a, b, cin, robid, wbs);
         else idle();
         if (g && q.size() != 0) void'(q.pop_front());
         if (tx && !exp_busy) begin
            r = ref_alu(int'(op), int'(a), int'(b), int'(cin));
            q.push_back({robid, r[7:0], r[15:8], wbs});
         end
         tick();
      end
      idle();
      bus.cdb_grant = 1'b0;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_mul();
      test_reset_mid();
      test_traffic();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/fu_alu.md
# fu_alu

Integer execution unit downstream of the reservation-station chain. It accepts one issued micro-op per cycle from the FU issue bus (the shared operand/wbs/depvals/flag/robid bus driven by the winning RS), computes an 8-bit result and flags, and buffers completions in a small result queue. It arbitrates for the common data bus (CDB) that feeds every RS's `depins`/`depinval` wake-up port and the ROB.

## Interface
- `RQ_DEPTH`, default 2: result-queue entries; power of two, minimum 2.
- `MUL_LAT`, default 3: extra cycles a MUL spends in the multiplier before it enters the queue.
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `futransmit` in 1: issue-bus valid, from the RS chain.
- `operand` in 8: micro-op; `[3:0]` is the opcode and `[7:4]` is reserved (ignored).
- `wbs` in 8: write-back selector; passed through unchanged to `cdb_wbs`.
- `depvals` in 2x8: source values; `[0]` is A, `[1]` is B.
- `flag` in 8: input flags; `[0]` is carry-in.
- `robid` in 4: destination ROB tag.
- `fu_busy` out 1: asserted means the unit cannot accept an op this cycle. Drives the `fuclaimed` input of the head RS.
- `cdb_req` out 1: a result is pending.
- `cdb_grant` in 1: CDB arbiter grant. The head result is consumed on any cycle where `cdb_req && cdb_grant`.
- `cdb_robid` out 4: result tag. Drives `depins` on the CDB.
- `cdb_val` out 8: result value. Drives `depinval`.
- `cdb_flags` out 8: result flags.
- `cdb_wbs` out 8: echoed `wbs`.

## Operation
- **Opcodes:** ADD=0, ADC=1, SUB=2, AND=3, OR=4, XOR=5, SHL=6, SHR=7, PASS=8, MUL=9. Codes 10–15 are ILLEGAL.
- **Arithmetic rules:**
  - All arithmetic is 8-bit and wraps modulo 256.
  - SHL/SHR shift A by `B[2:0]`; vacated bits fill with 0.
  - MUL produces the low 8 bits of A*B.
  - PASS returns B.
- **Output flags:** bit0 C, bit1 Z, bit2 N (result[7]), bit3 V, bit7 ILLEGAL; bits 6:4 are 0.
  - C is the carry out for ADD/ADC and the borrow for SUB. For SHL/SHR it is the last bit shifted out, or 0 when the shift is 0.
  - V is the signed overflow for ADD/ADC/SUB, and 0 otherwise.
  - Z is (result==0).
- **ILLEGAL opcodes:** result is 0, bit7=1, and Z=1.
- **Accept condition:** an op is accepted when `futransmit && !fu_busy`.
  - If `futransmit` is high while `fu_busy` is high, the op is ignored. The RS holds it because `fu_busy` drives its `fuclaimed` input.
- **`fu_busy`** = (queue occupancy + ops in flight ≥ `RQ_DEPTH`) or (multiplier state ≠ IDLE). This rule guarantees that every accepted op has a reserved queue slot.
- **Multiplier FSM:**
  - IDLE → MUL on accepting a MUL. The tag, `wbs` and operands are latched, and a counter is loaded with `MUL_LAT`.
  - The FSM stays in MUL while the counter decrements.
  - At 0 it moves to DONE, writes the queue, and returns to IDLE in the same cycle.
  - Single-cycle ops and MUL never write the queue in the same cycle, because `fu_busy` blocks issue during MUL.
- **Result queue:** FIFO ordered by completion. `cdb_*` shows the head entry combinationally.
  - When the queue is empty, `cdb_req`=0 and `cdb_robid`/`cdb_val`/`cdb_flags`/`cdb_wbs` are all 0. ROB tag 0 is reserved as the idle CDB tag and is never allocated.
- **Simultaneous push and pop:**
  - On a full queue this is legal; occupancy is unchanged.
  - On an empty queue the push enqueues and the pop does nothing; a result never bypasses the queue.
- **Pointer wrap:** pointers are `log2(RQ_DEPTH)` bits plus 1 wrap bit. Full = same index with opposite wrap bit.

## Timing
- **Reset:** all outputs are 0, the queue is empty, and the FSM is IDLE. `fu_busy`=0 in the cycle after reset deasserts.
- **Reset mid-operation:** any in-flight MUL and all queued results are discarded. Nothing is emitted afterwards.
- **Single-cycle op latency:** accepted at edge N → `cdb_req` high after edge N+1.
- **MUL latency:** accepted at edge N → `cdb_req` high after edge N+1+`MUL_LAT`. `fu_busy` is high from after edge N until after the edge that writes the queue.
- **Throughput:** one single-cycle op per clock while the CDB grants every cycle.
- **`cdb_req`:** once asserted it stays high and the `cdb_*` values stay stable until granted.

## Configuration
- **`FU_MUL_EN` defined:** the multiplier FSM and datapath are built as described above.
- **`FU_MUL_EN` undefined:** the multiplier FSM and datapath are not built. MUL decodes as ILLEGAL and completes in 1 cycle with result 0 and flags 8'h82. `MUL_LAT` is ignored.

## Structure
- **Package `fu_pkg`:** opcode enum, flag bit-index constants, `CDB_IDLE_TAG`=4'h0, and a `cdb_entry_t` struct {robid, val, flags, wbs}.
- **Sub-module `fu_result_fifo`:** parameterised by depth and element type `cdb_entry_t`. It provides push/pop/full/empty and a count.
- **Top module:** holds the decode, ALU, multiplier FSM and busy logic.

## Test plan
- ADD A=8'h7F, B=8'h01, robid=3 → one cycle later `cdb_req`=1, `cdb_robid`=3, `cdb_val`=8'h80, flags=8'h0C (N, V).
- SUB A=5, B=5 → `cdb_val`=0, flags=8'h02. SUB A=0, B=1 → `cdb_val`=8'hFF, flags=8'h05.
- `cdb_grant` held at 0 with `RQ_DEPTH`=2; issue 3 ADDs back to back → the first two are accepted and `fu_busy`=1 for the third. Grant once → head pops, `fu_busy` drops, the third is accepted. Results come out in order.
- MUL A=8'h10, B=8'h11 with `MUL_LAT`=3 → `fu_busy` high for 4 cycles, then `cdb_val`=8'h10. Without `FU_MUL_EN`: `cdb_val`=0, flags=8'h82 after 1 cycle.
- Opcode 4'hC → flags=8'h82. Assert `rst` during a MUL with one queued result → next cycle `cdb_req`=0, all outputs 0, no late emission.
- Full queue with a simultaneous grant and new issue over 20 cycles → no loss or duplication; occupancy constant; pointers wrap correctly.
